// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_e  : FSM state encoding
//   F3_*         : RISC-V funct3 size/sign codes
//   f3_illegal   : funct3 not legal for the given access direction
//   misaligned   : access not naturally aligned for its size
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_RD = 3'd1,
        ST_RD = 3'd2,
        ST_WR = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know B/H/W; loads additionally allow BU/HU.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            f3_illegal = (funct3 > F3_W);
        end else begin
            f3_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
    endfunction

    // funct3[1:0] carries the access size for every legal code.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
        case (funct3[1:0])
            2'b01:   misaligned = byte_off[0];
            2'b10:   misaligned = (byte_off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
//   funct3     : access size/sign code
//   byte_off   : byte offset within the word
//   rdata      : word read from memory
//   wdata      : low half of store data (byte or halfword source)
//   load_ext_c : little-endian extracted and extended load result
//   merged_c   : rdata with the addressed byte/half replaced by wdata
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] rdata,
    input  logic [15:0]     wdata,
    output logic [XLEN-1:0] load_ext_c,
    output logic [XLEN-1:0] merged_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign byte_c = rdata[{byte_off, 3'b000} +: 8];
    assign half_c = rdata[{byte_off[1], 4'b0000} +: 16];

    // Load extraction and extension.
    always_comb begin
        load_ext_c = '0;
        case (funct3)
            F3_B:    load_ext_c = {{(XLEN-8){byte_c[7]}}, byte_c};
            F3_BU:   load_ext_c = {{(XLEN-8){1'b0}}, byte_c};
            F3_H:    load_ext_c = {{(XLEN-16){half_c[15]}}, half_c};
            F3_HU:   load_ext_c = {{(XLEN-16){1'b0}}, half_c};
            F3_W:    load_ext_c = rdata;
            default: load_ext_c = '0;
        endcase
    end

    // Sub-word store merge into the old word.
    always_comb begin
        merged_c = rdata;
        case (funct3[1:0])
            2'b00:   merged_c[{byte_off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   merged_c[{byte_off[1], 4'b0000} +: 16] = wdata;
            default: merged_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed data memory
// without byte enables. Sub-word stores use read-modify-write.
//   clk, reset          : clock, async active-high reset
//   req_*               : core request, held until done
//   busy                : accept edge through end of RESP (core stalls)
//   done                : one-cycle completion pulse
//   load_data           : extended load result, valid with done
//   access_fault        : access aborted, valid with done
//   mem_read/mem_write  : registered memory strobes (never both high)
//   mem_address         : registered word address
//   mem_write_data      : registered store word
//   mem_read_data       : combinational memory read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   load_data,
    output logic              access_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [XLEN-1:0]   mem_write_data,
    input  logic [XLEN-1:0]   mem_read_data
);

    localparam int unsigned BA_W = ADDR_W + 2;

    lsu_state_e      state_q, state_d;
    logic [BA_W-1:0] addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;

    logic            busy_d, done_d, fault_d, mem_read_d, mem_write_d;
    logic [XLEN-1:0] load_data_d, mem_write_data_d;
    logic [XLEN-1:0] load_ext_c, merged_c;
    logic            req_fault_c;

    assign req_fault_c = f3_illegal(req_is_store, req_funct3)
                       || misaligned(req_funct3, req_addr[1:0])
                       || (|req_addr[XLEN-1:BA_W]);

    // The address register feeds the memory directly, so it is already a flop.
    assign mem_address = addr_q[BA_W-1:2];

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (funct3_q),
        .byte_off   (addr_q[1:0]),
        .rdata      (mem_read_data),
        .wdata      (wdata_q),
        .load_ext_c (load_ext_c),
        .merged_c   (merged_c)
    );

    // Next state and next registered outputs. The RMW merged word is captured
    // straight into mem_write_data on the ST_RD -> ST_WR edge.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        funct3_d         = funct3_q;
        done_d           = 1'b0;
        fault_d          = access_fault;
        load_data_d      = load_data;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        mem_write_data_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr[BA_W-1:0];
                    wdata_d     = req_wdata[15:0];
                    funct3_d    = req_funct3;
                    load_data_d = '0;
                    fault_d     = 1'b0;
                    if (req_fault_c) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else if (!req_is_store) begin
                        state_d    = LD_RD;
                        mem_read_d = 1'b1;
                    end else if (req_funct3 == F3_W) begin
                        state_d          = ST_WR;
                        mem_write_d      = 1'b1;
                        mem_write_data_d = req_wdata;
                    end else begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            LD_RD: begin
                state_d     = RESP;
                done_d      = 1'b1;
                load_data_d = load_ext_c;
            end
            ST_RD: begin
                state_d          = ST_WR;
                mem_write_d      = 1'b1;
                mem_write_data_d = merged_c;
            end
            ST_WR: begin
                state_d = RESP;
                done_d  = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            funct3_q       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            access_fault   <= 1'b0;
            load_data      <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            funct3_q       <= funct3_d;
            busy           <= busy_d;
            done           <= done_d;
            access_fault   <= fault_d;
            load_data      <= load_data_d;
            mem_read       <= mem_read_d;
            mem_write      <= mem_write_d;
            mem_write_data <= mem_write_data_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus random
// accesses checked against a behavioural memory/alignment model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_is_store;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr, req_wdata;
    logic              busy, done, access_fault, mem_read, mem_write;
    logic [XLEN-1:0]   load_data, mem_write_data, mem_read_data;
    logic [ADDR_W-1:0] mem_address;

    load_store_unit #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .done           (done),
        .load_data      (load_data),
        .access_fault   (access_fault),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory seen by the DUT; ref_mem is the model's own copy.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    assign mem_read_data = mem[mem_address];
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

    int checks = 0;
    int errors = 0;

    int          obs_lat, obs_rd, obs_wr, obs_both;
    logic [13:0] obs_rd_addr, obs_wr_addr;
    logic [31:0] obs_wr_data, obs_ld;
    logic        obs_fault;

    // Issue one request at a negedge and observe it until done (bounded).
    task automatic do_access(input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        obs_lat = 0; obs_rd = 0; obs_wr = 0; obs_both = 0;
        obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
        obs_ld = 32'hxxxxxxxx; obs_fault = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_read === 1'b1) begin obs_rd++; obs_rd_addr = mem_address; end
            if (mem_write === 1'b1) begin
                obs_wr++; obs_wr_addr = mem_address; obs_wr_data = mem_write_data;
            end
            if (mem_read === 1'b1 && mem_write === 1'b1) obs_both++;
            if (done === 1'b1) begin
                obs_lat = c; obs_ld = load_data; obs_fault = access_fault;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    // Behavioural model: legality, expected result, timing and memory update.
    task automatic ref_access(input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic e_fault, output logic [31:0] e_ld,
                              output int e_lat, output int e_rd, output int e_wr,
                              output logic [31:0] e_wdata);
        int unsigned size, sh, widx;
        logic [31:0] w, v, mask;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e_fault = 1'b0;
        if (st && f3 > 3'd2) e_fault = 1'b1;
        if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) e_fault = 1'b1;
        if (a % size != 0) e_fault = 1'b1;
        if (a >= (32'd1 << (ADDR_W + 2))) e_fault = 1'b1;
        widx = (a / 4) % DEPTH;
        sh   = (a % 4) * 8;
        w    = ref_mem[widx];
        e_ld = '0; e_rd = 0; e_wr = 0; e_wdata = '0;
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFFFFFF;
        if (e_fault) begin
            e_lat = 1;
        end else if (!st) begin
            e_lat = 2; e_rd = 1;
            v = (w >> sh) & mask;
            if (f3 == 3'd0 && v >= 32'd128)   v = v - 32'd256;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            e_ld = v;
        end else begin
            e_wr = 1;
            if (size == 4) begin
                e_lat = 2; e_wdata = wd;
            end else begin
                e_lat = 3; e_rd = 1;
                e_wdata = (w & ~(mask << sh)) | ((wd & mask) << sh);
            end
            ref_mem[widx] = e_wdata;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, access_fault, mem_read, mem_write} !== 5'b0 ||
            load_data !== 32'h0 || mem_write_data !== 32'h0 || mem_address !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b fault=%b rd=%b wr=%b ld=%h wd=%h ma=%h exp all zero",
                     busy, done, access_fault, mem_read, mem_write, load_data, mem_write_data, mem_address);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loads;
        logic [2:0] f3; logic [31:0] a, e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin f3 = F3_B;  a = 32'h101; e = 32'hFFFFFFAA; end
                1:       begin f3 = F3_BU; a = 32'h103; e = 32'h00000088; end
                2:       begin f3 = F3_H;  a = 32'h102; e = 32'hFFFF8899; end
                3:       begin f3 = F3_HU; a = 32'h100; e = 32'h0000AABB; end
                default: begin f3 = F3_W;  a = 32'h100; e = 32'h8899AABB; end
            endcase
            do_access(1'b0, f3, a, 32'h0);
            checks++;
            if (obs_ld !== e || obs_fault !== 1'b0) begin
                errors++;
                $display("FAIL load_data[%0d] got %h fault=%b exp %h fault=0", i, obs_ld, obs_fault, e);
            end
            checks++;
            if (obs_lat != 2 || obs_rd != 1 || obs_wr != 0 || obs_rd_addr !== 14'h40) begin
                errors++;
                $display("FAIL load_timing[%0d] got lat=%0d rd=%0d wr=%0d addr=%h exp lat=2 rd=1 wr=0 addr=040",
                         i, obs_lat, obs_rd, obs_wr, obs_rd_addr);
            end
        end
    endtask

    task automatic test_store_byte;
        do_access(1'b1, F3_B, 32'h102, 32'h12345677);
        ref_mem[32'h40] = 32'h8877AABB;
        checks++;
        if (obs_lat != 3 || obs_rd != 1 || obs_wr != 1 || obs_both != 0 ||
            obs_wr_data !== 32'h8877AABB || obs_wr_addr !== 14'h40 || obs_ld !== 32'h0 || obs_fault !== 1'b0) begin
            errors++;
            $display("FAIL sb_rmw got lat=%0d rd=%0d wr=%0d both=%0d wd=%h wa=%h ld=%h exp lat=3 rd=1 wr=1 both=0 wd=8877aabb wa=040 ld=0",
                     obs_lat, obs_rd, obs_wr, obs_both, obs_wr_data, obs_wr_addr, obs_ld);
        end
        do_access(1'b0, F3_W, 32'h100, 32'h0);
        checks++;
        if (obs_ld !== 32'h8877AABB) begin
            errors++;
            $display("FAIL sb_readback got %h exp 8877aabb", obs_ld);
        end
    endtask

    task automatic test_store_word;
        do_access(1'b1, F3_W, 32'h104, 32'hDEADBEEF);
        ref_mem[32'h41] = 32'hDEADBEEF;
        checks++;
        if (obs_lat != 2 || obs_rd != 0 || obs_wr != 1 || obs_wr_addr !== 14'h41 ||
            obs_wr_data !== 32'hDEADBEEF || obs_ld !== 32'h0) begin
            errors++;
            $display("FAIL sw got lat=%0d rd=%0d wr=%0d wa=%h wd=%h ld=%h exp lat=2 rd=0 wr=1 wa=041 wd=deadbeef ld=0",
                     obs_lat, obs_rd, obs_wr, obs_wr_addr, obs_wr_data, obs_ld);
        end
    endtask

    task automatic test_faults;
        logic [2:0] f3; logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin f3 = F3_W;   a = 32'h102;      end
                1:       begin f3 = F3_H;   a = 32'h1;        end
                2:       begin f3 = F3_B;   a = 32'h00010000; end
                default: begin f3 = 3'b011; a = 32'h100;      end
            endcase
            do_access(1'b0, f3, a, 32'h0);
            checks++;
            if (obs_lat != 1 || obs_fault !== 1'b1 || obs_ld !== 32'h0 || obs_rd != 0 || obs_wr != 0) begin
                errors++;
                $display("FAIL fault[%0d] got lat=%0d fault=%b ld=%h rd=%0d wr=%0d exp lat=1 fault=1 ld=0 rd=0 wr=0",
                         i, obs_lat, obs_fault, obs_ld, obs_rd, obs_wr);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h102; req_wdata = 32'hA5;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmw_read_phase got rd=%b busy=%b exp rd=1 busy=1", mem_read, busy);
        end
        #1 reset = 1'b1; req_valid = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rd=%b wr=%b busy=%b exp 0 0 0", mem_read, mem_write, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b done=%b rd=%b wr=%b exp all 0", busy, done, mem_read, mem_write);
        end
        do_access(1'b0, F3_W, 32'h100, 32'h0);
        checks++;
        if (obs_lat != 2 || obs_ld !== ref_mem[32'h40] || obs_fault !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_reset got lat=%0d ld=%h exp lat=2 ld=%h", obs_lat, obs_ld, ref_mem[32'h40]);
        end
    endtask

    task automatic test_random;
        logic st, e_fault; logic [2:0] f3; logic [31:0] a, wd, e_ld, e_wd;
        int e_lat, e_rd, e_wr;
        for (int i = 0; i < 120; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(16, 31));
            wd = $urandom;
            ref_access(st, f3, a, wd, e_fault, e_ld, e_lat, e_rd, e_wr, e_wd);
            do_access(st, f3, a, wd);
            checks++;
            if (obs_fault !== e_fault || obs_ld !== e_ld || obs_lat != e_lat || obs_rd != e_rd ||
                obs_wr != e_wr || obs_both != 0 || (e_wr == 1 && (obs_wr_data !== e_wd ||
                obs_wr_addr !== 14'((a >> 2) % DEPTH)))) begin
                errors++;
                $display("FAIL random[%0d] st=%b f3=%0d a=%h got fault=%b ld=%h lat=%0d rd=%0d wr=%0d wd=%h exp fault=%b ld=%h lat=%0d rd=%0d wr=%0d wd=%h",
                         i, st, f3, a, obs_fault, obs_ld, obs_lat, obs_rd, obs_wr, obs_wr_data,
                         e_fault, e_ld, e_lat, e_rd, e_wr, e_wd);
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = $urandom;
            if (i == 32'h40) v = 32'h8899AABB;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        test_reset();
        test_loads();
        test_store_byte();
        test_store_word();
        test_faults();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
